imem_load_ctrl: RTL and testbench

//  Boot-time loader and port arbiter for the byte-addressed, asynchronous-read instruction memory.
//  - Receives a program as a byte stream over a valid/ready link and writes it to memory as 32-bit words.
//  - Holds the core in hold until the image is loaded and its checksum verified.
//  - Then hands the memory read port to the fetch stage.

---
 rtl/imem_load_ctrl.sv | 146 ++++++++++++++
 tb/tb_imem_load_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_load_ctrl: boot loader (LEN/data/CSUM byte stream -> 32-bit words)  |
// | and instruction-memory port arbiter between the loader and fetch.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imem_load_ctrl #(
  parameter int          ADDR_W    = 20,
  parameter int          MAX_WORDS = 262144,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-2:0] words_loaded
);

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [31:0]       MAX_WORDS_C = 32'(MAX_WORDS);
  localparam logic [ADDR_W-2:0] WL_ONE      = (ADDR_W-1)'(1);

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       sum_q, sum_d;
  logic [ADDR_W-2:0] words_loaded_q, words_loaded_d;

  logic              accept;
  logic              last_byte;
  logic [31:0]       word_in;
  logic [ADDR_W-2:0] wl_inc;

  // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
  assign word_in   = {rx_data, shift_q[31:8]};
  assign rx_ready  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept    = rx_valid && rx_ready;
  assign last_byte = accept && (byte_idx_q == 2'd3);
  assign wl_inc    = words_loaded_q + WL_ONE;

  assign mem_wdata    = shift_q;
  assign words_loaded = words_loaded_q;

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    shift_d        = shift_q;
    len_d          = len_q;
    sum_d          = sum_q;
    words_loaded_d = words_loaded_q;
    mem_we         = 1'b0;
    core_hold      = 1'b1;
    load_done      = 1'b0;
    load_err       = 1'b0;
    fetch_instr    = NOP_INSTR;
    mem_addr       = {words_loaded_q[ADDR_W-3:0], 2'b00};

    if (accept) begin
      shift_d    = word_in;
      byte_idx_d = byte_idx_q + 2'd1;
    end

    case (state_q)
      ST_LEN: begin
        if (last_byte) begin
          len_d = word_in;
          if (word_in > MAX_WORDS_C) state_d = ST_ERR;
          else if (word_in == 32'd0) state_d = ST_CSUM;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_byte) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we         = 1'b1;
        sum_d          = sum_q + shift_q;
        words_loaded_d = wl_inc;
        state_d        = (32'(wl_inc) == len_q) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (last_byte) state_d = (word_in == sum_q) ? ST_RUN : ST_ERR;
      end
      ST_RUN: begin
        core_hold   = 1'b0;
        load_done   = 1'b1;
        mem_addr    = fetch_addr;
        fetch_instr = mem_rdata;
      end
      ST_ERR: begin
        load_err = 1'b1;
      end
      default: state_d = ST_LEN;
    endcase

    if (reload && ((state_q == ST_RUN) || (state_q == ST_ERR))) begin
      state_d        = ST_LEN;
      len_d          = 32'd0;
      sum_d          = 32'd0;
      words_loaded_d = '0;
    end

    // Every state starts assembling from byte 0.
    if (state_d != state_q) byte_idx_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_LEN;
      byte_idx_q     <= 2'd0;
      shift_q        <= 32'd0;
      len_q          <= 32'd0;
      sum_q          <= 32'd0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      len_q          <= len_d;
      sum_q          <= sum_d;
      words_loaded_q <= words_loaded_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_load_ctrl: directed self-checking bench for imem_load_ctrl.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_imem_load_ctrl;

  localparam int          ADDR_W = 20;
  localparam int          MAXW   = 262144;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-2:0] words_loaded;

  imem_load_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous write, asynchronous read.
  logic [31:0] bmem [0:255];
  always @(posedge clk) if (mem_we) bmem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = bmem[mem_addr[9:2]];

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: parse the byte stream into expected writes and outcome.
  typedef struct { logic [19:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [31:0] exp_mem [0:255];
  logic [7:0]  stream[$];
  bit          exp_ok;
  int          exp_words;

  function automatic logic [31:0] get_w(input int off);
    return {stream[off+3], stream[off+2], stream[off+1], stream[off]};
  endfunction

  task automatic push_w(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
  endtask

  task automatic model_parse();
    logic [31:0] len, sum, w;
    wr_t e;
    exp_wr.delete();
    len = get_w(0);
    if (len > 32'(MAXW)) begin
      exp_ok = 1'b0; exp_words = 0;
      return;
    end
    sum = 32'd0;
    for (int i = 0; i < int'(len); i++) begin
      w   = get_w(4 + 4*i);
      e.a = 20'(i*4);
      e.d = w;
      exp_wr.push_back(e);
      sum = sum + w;
    end
    exp_ok    = (get_w(4 + 4*int'(len)) == sum);
    exp_words = int'(len);
  endtask

  task automatic mk_t1();
    stream.delete();
    push_w(32'd2); push_w(32'h00A00213); push_w(32'h0200C063); push_w(32'h02A0C276);
  endtask

  // Per-cycle checker, sampling on the falling edge.
  int     wl_m = 0;
  bit     pend_clr = 1'b0, pend_inc = 1'b0;
  longint cyc_n = 0, last_we = -100;
  int     we_cnt = 0;

  always @(negedge clk) begin
    wr_t e;
    cyc_n++;
    if (pend_clr) wl_m = 0;
    else if (pend_inc) wl_m++;
    pend_clr = rst || (reload && (!core_hold || load_err));
    pend_inc = mem_we;
    if (!rst) begin
      chk("words_loaded", 64'(words_loaded), 64'(wl_m));
      chk("load_done_vs_hold", 64'(load_done), 64'(!core_hold));
      chk("rx_ready_rule", 64'(rx_ready), 64'(core_hold && !load_err && !mem_we));
      if (core_hold) begin
        chk("fetch_nop", 64'(fetch_instr), 64'(NOP));
        chk("mem_addr_load", 64'(mem_addr), 64'(wl_m*4));
      end else begin
        chk("mem_addr_run", 64'(mem_addr), 64'(fetch_addr));
        chk("fetch_run", 64'(fetch_instr), 64'(exp_mem[fetch_addr[9:2]]));
        chk("load_err_run", 64'(load_err), 64'd0);
      end
      if (mem_we) begin
        we_cnt++;
        chk("we_spacing", 64'(cyc_n - last_we >= 5), 64'd1);
        last_we = cyc_n;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", mem_addr, mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("write_addr", 64'(mem_addr), 64'(e.a));
          chk("write_data", 64'(mem_wdata), 64'(e.d));
          exp_mem[e.a[9:2]] = e.d;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit do_reload);
    bit acc;
    int n;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0; rx_data = 8'($urandom);
      step();
    end
    rx_valid = 1'b1; rx_data = b; reload = do_reload;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = rx_ready;
      step();
      reload = 1'b0;
      n++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, want accept", n);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int max_gap, input int reload_at, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      send_byte(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, i == reload_at);
  endtask

  task automatic check_final(input string tag);
    @(negedge clk);
    chk({tag, "_load_done"}, 64'(load_done), 64'(exp_ok));
    chk({tag, "_load_err"}, 64'(load_err), 64'(!exp_ok));
    chk({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_ok));
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
    chk({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    step();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    @(negedge clk);
    chk("reload_hold", 64'(core_hold), 64'd1);
    chk("reload_done", 64'(load_done), 64'd0);
    chk("reload_err", 64'(load_err), 64'd0);
    chk("reload_words", 64'(words_loaded), 64'd0);
    chk("reload_ready", 64'(rx_ready), 64'd1);
    step();
  endtask

  task automatic fetch_pin(input logic [19:0] a, input logic [31:0] want);
    fetch_addr = a;
    @(negedge clk);
    chk("fetch_pin", 64'(fetch_instr), 64'(want));
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin bmem[i] = 32'd0; exp_mem[i] = 32'd0; end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0; fetch_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_core_hold", 64'(core_hold), 64'd1);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_fetch", 64'(fetch_instr), 64'(NOP));
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    step();
    fetch_addr = 20'd4;

    // T1: two-word image, back-to-back bytes
    mk_t1(); model_parse();
    send_stream(0, -1, stream.size());
    check_final("t1");
    fetch_pin(20'd4, 32'h0200C063);
    fetch_pin(20'd0, 32'h00A00213);
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) step();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("t1_run_ignores_rx", 64'(words_loaded), 64'd2);
    chk("t1_run_done", 64'(load_done), 64'd1);
    step();

    // T2: empty image
    do_reload();
    stream.delete(); push_w(32'd0); push_w(32'd0); model_parse();
    we0 = we_cnt;
    send_stream(0, -1, stream.size());
    check_final("t2");
    chk("t2_no_writes", 64'(we_cnt - we0), 64'd0);

    // T3: bad checksum then recovery via reload
    do_reload();
    stream.delete(); push_w(32'd1); push_w(32'h00000013); push_w(32'h00000014); model_parse();
    send_stream(0, -1, stream.size());
    check_final("t3");
    chk("t3_err_pin", 64'(load_err), 64'd1);
    do_reload();
    mk_t1(); model_parse();
    send_stream(0, -1, stream.size());
    check_final("t3r");

    // T4: oversize length
    do_reload();
    stream.delete(); push_w(32'h00040001); model_parse();
    we0 = we_cnt;
    send_stream(0, -1, 4);
    check_final("t4");
    chk("t4_no_writes", 64'(we_cnt - we0), 64'd0);
    chk("t4_err_pin", 64'(load_err), 64'd1);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) step();
    rx_valid = 1'b0;

    // T5: random gaps, reload pulse mid-load must be ignored
    do_reload();
    mk_t1(); model_parse();
    send_stream(5, 6, stream.size());
    check_final("t5");
    fetch_pin(20'd4, 32'h0200C063);

    // T6: reset mid-load, then full restream
    do_reload();
    mk_t1(); model_parse();
    send_stream(0, -1, 10);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    exp_wr.delete();
    @(negedge clk);
    chk("t6_rx_ready", 64'(rx_ready), 64'd1);
    chk("t6_words", 64'(words_loaded), 64'd0);
    chk("t6_hold", 64'(core_hold), 64'd1);
    chk("t6_done", 64'(load_done), 64'd0);
    step();
    model_parse();
    send_stream(0, -1, stream.size());
    check_final("t6");
    fetch_pin(20'd4, 32'h0200C063);
    fetch_pin(20'd0, 32'h00A00213);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
